// File: rtl/ycr_timer_arb_if.sv
// ycr_timer_arb_if: request/acknowledge/response memory bus between a requester and the arbiter or timer slave
interface ycr_timer_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          cmd;
  logic [1:0]    width;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          req_ack;
  logic [DW-1:0] rdata;
  logic [1:0]    resp;
  modport master (output req, cmd, width, addr, wdata, input req_ack, rdata, resp);
  modport slave (input req, cmd, width, addr, wdata, output req_ack, rdata, resp);
endinterface

// File: rtl/ycr_timer_arb.sv
// ycr_timer_arb: two-port round-robin arbiter in front of the timer slave with response timeout
module ycr_timer_arb #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 15
) (
  input  logic             clk,
  input  logic             rst,
  ycr_timer_arb_if.slave   p0,
  ycr_timer_arb_if.slave   p1,
  ycr_timer_arb_if.master  tmr,
  output logic             busy
);
  localparam logic [1:0] NOTRDY = 2'd0;
  localparam logic [1:0] RDY_ER = 2'd2;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  state_e        state_q, state_d;
  logic          last_q, ack_q, cmd_q;
  logic [1:0]    width_q, resp_q;
  logic [7:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic          any_req, gnt, grant, tmo, rsp_v, cap;
  assign any_req = p0.req | p1.req;
  assign gnt     = (p0.req & p1.req) ? ~last_q : p1.req;
  assign grant   = (state_q == IDLE) & any_req;
  assign tmo     = cnt_q == 8'(TMO - 1);
  assign rsp_v   = tmr.resp != NOTRDY;
  assign cap     = (state_q == WAIT) & rsp_v;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // next state: timeout beats a late ack in REQ, a slave response beats the timeout in WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? REQ : IDLE;
      REQ:     state_d = tmo ? RESP : (tmr.req_ack ? WAIT : REQ);
      WAIT:    state_d = (rsp_v | tmo) ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
  end
  // grant bookkeeping, request latch, timeout counter and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= 1'b1;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      cmd_q   <= 1'b0;
      width_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= NOTRDY;
    end else begin
      ack_q <= grant;
      if (grant) begin
        last_q  <= gnt;
        cnt_q   <= '0;
        cmd_q   <= gnt ? p1.cmd : p0.cmd;
        width_q <= gnt ? p1.width : p0.width;
        addr_q  <= gnt ? p1.addr : p0.addr;
        wdata_q <= gnt ? p1.wdata : p0.wdata;
      end else if (state_q == REQ || state_q == WAIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (state_d == RESP && state_q != RESP) begin
        resp_q  <= cap ? tmr.resp : RDY_ER;
        rdata_q <= cap ? tmr.rdata : '0;
      end
    end
  end
  // outputs: only the granted port sees the response, and only in RESP
  always_comb begin
    busy       = state_q != IDLE;
    tmr.req    = state_q == REQ;
    tmr.cmd    = cmd_q;
    tmr.width  = width_q;
    tmr.addr   = addr_q;
    tmr.wdata  = wdata_q;
    p0.req_ack = ack_q & ~last_q;
    p1.req_ack = ack_q & last_q;
    p0.resp    = (state_q == RESP && !last_q) ? resp_q : NOTRDY;
    p1.resp    = (state_q == RESP && last_q) ? resp_q : NOTRDY;
    p0.rdata   = (state_q == RESP && !last_q) ? rdata_q : '0;
    p1.rdata   = (state_q == RESP && last_q) ? rdata_q : '0;
  end
endmodule

// File: tb/tb_ycr_timer_arb.sv
// tb_ycr_timer_arb: directed and random transactions against a cycle-count reference model
module tb_ycr_timer_arb;
  localparam int TMO = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int vecs = 0;
  int errs = 0;
  bit lastg;
  bit m_cmd[2];
  logic [1:0] m_w[2];
  logic [31:0] m_a[2], m_d[2];
  int s_ad, s_rd, s_k;
  bit s_en, s_act, s_cmd;
  logic [1:0] s_resp;
  logic [31:0] s_addr, s_key;
  always #5 clk = ~clk;
  ycr_timer_arb_if #(.AW(32), .DW(32)) p0_if ();
  ycr_timer_arb_if #(.AW(32), .DW(32)) p1_if ();
  ycr_timer_arb_if #(.AW(32), .DW(32)) tmr_if ();
  ycr_timer_arb #(.AW(32), .DW(32), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if), .tmr(tmr_if), .busy(busy)
  );
  // timer slave: ack s_ad cycles after it sees tmr_req, respond s_rd+1 cycles after the ack
  initial begin
    s_act = 0;
    s_k = 0;
    tmr_if.req_ack = 0;
    tmr_if.resp = 0;
    tmr_if.rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      tmr_if.req_ack = 0;
      tmr_if.resp = 0;
      tmr_if.rdata = 0;
      if (rst) s_act = 0;
      else begin
        if (!s_act && s_en && tmr_if.req) begin
          s_act = 1; s_k = 0; s_cmd = tmr_if.cmd; s_addr = tmr_if.addr;
        end else if (s_act) s_k++;
        if (s_act && s_k == s_ad) tmr_if.req_ack = 1;
        if (s_act && s_k == s_ad + 1 + s_rd) begin
          tmr_if.resp = s_resp;
          tmr_if.rdata = s_cmd ? 32'd0 : (s_addr ^ s_key);
          s_act = 0;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic setp(input int p, input bit c, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    m_cmd[p] = c; m_w[p] = w; m_a[p] = a; m_d[p] = d;
    if (p == 0) begin p0_if.cmd = c; p0_if.width = w; p0_if.addr = a; p0_if.wdata = d; end
    else begin p1_if.cmd = c; p1_if.width = w; p1_if.addr = a; p1_if.wdata = d; end
  endtask
  // A transaction spends n = ad+rd+2 cycles in REQ/WAIT; beyond TMO cycles it is cut to TMO with RDY_ER.
  task automatic txn(input bit r0, input bit r1, input int ad, input int rd, input bit en, input logic [1:0] sr);
    int n, m, tl, endc, c;
    int a[2], rc[2];
    bit f, ok, pair;
    logic [1:0] er;
    logic [31:0] ed[2];
    s_ad = ad; s_rd = rd; s_en = en; s_resp = sr;
    pair = r0 && r1;
    n = ad + rd + 2;
    ok = en && n <= TMO;
    m = ok ? n : TMO;
    tl = (en && ad + 1 < TMO) ? ad + 1 : TMO;
    er = ok ? sr : 2'd2;
    for (int p = 0; p < 2; p++) ed[p] = (ok && !m_cmd[p]) ? (m_a[p] ^ s_key) : 32'd0;
    f = pair ? !lastg : r1;
    a[f] = 1;
    rc[f] = 1 + m;
    a[!f] = pair ? 3 + m : -100;
    rc[!f] = pair ? 3 + 2 * m : -100;
    lastg = pair ? !f : f;
    endc = (pair ? 3 + 2 * m : 1 + m) + 2;
    @(negedge clk);
    p0_if.req = r0;
    p1_if.req = r1;
    c = 1;
    while (c <= endc || (s_act && c < 400)) begin
      int g;
      @(negedge clk);
      chk("ack", {p1_if.req_ack, p0_if.req_ack}, {c == a[1], c == a[0]});
      chk("resp0", {p0_if.resp, p0_if.rdata}, (c == rc[0]) ? {er, ed[0]} : 34'd0);
      chk("resp1", {p1_if.resp, p1_if.rdata}, (c == rc[1]) ? {er, ed[1]} : 34'd0);
      chk("busy", busy, (c >= a[0] && c <= rc[0]) || (c >= a[1] && c <= rc[1]));
      g = (c >= a[0] && c < a[0] + tl) ? 0 : ((c >= a[1] && c < a[1] + tl) ? 1 : -1);
      chk("tmr_req", tmr_if.req, g >= 0);
      if (g >= 0)
        chk("tmr_fields", {tmr_if.cmd, tmr_if.width, tmr_if.addr, tmr_if.wdata}, {m_cmd[g], m_w[g], m_a[g], m_d[g]});
      if (p0_if.req_ack) p0_if.req = 0;
      if (p1_if.req_ack) p1_if.req = 0;
      c++;
    end
    chk("slave_done", s_act, 1'b0);
  endtask
  initial begin
    p0_if.req = 0;
    p1_if.req = 0;
    setp(0, 0, 2'd0, 32'd0, 32'd0);
    setp(1, 0, 2'd0, 32'd0, 32'd0);
    s_en = 0; s_key = 0; s_ad = 0; s_rd = 0; s_resp = 0;
    lastg = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tmr", {tmr_if.req, tmr_if.cmd, tmr_if.width, tmr_if.addr, tmr_if.wdata}, 68'd0);
    chk("rst_ports", {p0_if.req_ack, p1_if.req_ack, p0_if.resp, p1_if.resp, p0_if.rdata, p1_if.rdata}, 70'd0);
    rst = 0;
    @(negedge clk);
    setp(0, 0, 2'd2, 32'h100, 32'h11);
    setp(1, 1, 2'd1, 32'h204, 32'h22);
    s_key = 32'h5A5A_0F0F;
    txn(1, 1, 1, 1, 1, 2'd1);
    txn(1, 1, 0, 2, 1, 2'd2);
    s_key = 32'h0000_123C;
    setp(0, 0, 2'd2, 32'h8, 32'h0);
    txn(1, 0, 1, 1, 1, 2'd1);
    setp(1, 1, 2'd2, 32'h10, 32'hA5);
    txn(0, 1, 1, 1, 1, 2'd1);
    setp(0, 0, 2'd2, 32'h30, 32'h0);
    txn(1, 0, 0, 0, 0, 2'd1);
    txn(1, 0, 16, 2, 1, 2'd1);
    txn(1, 0, 2, 11, 1, 2'd1);
    txn(0, 1, 2, 12, 1, 2'd1);
    setp(0, 0, 2'd2, 32'h44, 32'h0);
    s_ad = 0; s_rd = 10; s_en = 1; s_resp = 2'd1;
    @(negedge clk);
    p0_if.req = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (p0_if.req_ack) p0_if.req = 0;
    end
    chk("wait_busy", busy, 1'b1);
    rst = 1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_tmr", {tmr_if.req, tmr_if.addr}, 33'd0);
    chk("abort_ports", {p0_if.req_ack, p1_if.req_ack, p0_if.resp, p1_if.resp, p0_if.rdata, p1_if.rdata}, 70'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_resp", {p0_if.resp, p1_if.resp, busy}, 5'd0);
    end
    rst = 0;
    lastg = 1;
    setp(1, 0, 2'd1, 32'h77, 32'h0);
    txn(1, 1, 1, 1, 1, 2'd1);
    setp(1, 1, 2'd2, 32'h88, 32'hC3);
    txn(0, 1, 1, 1, 1, 2'd1);
    for (int i = 0; i < 30; i++) begin
      int r, ad, rd;
      r = $urandom_range(1, 3);
      ad = $urandom_range(0, 5);
      rd = (r == 3) ? $urandom_range(0, 13 - ad) : $urandom_range(0, 14);
      s_key = $urandom;
      setp(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      setp(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      txn(r[0], r[1], ad, rd, 1, ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
